conv_frame_loader: RTL and testbench

- Parametrised successor to the switch-driven 6x6 row loader.
- Captures one image row per rising edge of a row strobe into an IMG_H x IMG_W frame buffer with PIX_W-bit pixels.
- Flags frame completion, then streams every valid KxK convolution window to the conv layer over a valid/ready handshake.
- Sits between the tt_um top-level switch/IO logic and convLayer, replacing the ad-hoc row array and the combinational matrix copy.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_window_mux.sv | 31 +++
 rtl/conv_frame_loader.sv | 155 +++++++++++++++
 tb/tb_conv_frame_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the convolution frame loader.
//   state_e : loader FSM states (LOAD / FULL / STREAM)
//   DEF_*   : default frame geometry (6x6 one-bit pixels, 3x3 window)
//   cw()    : index width for a count of n items, never less than 1 bit
package conv_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        FULL   = 2'd1,
        STREAM = 2'd2
    } state_e;

    localparam int DEF_IMG_W = 6;
    localparam int DEF_IMG_H = 6;
    localparam int DEF_PIX_W = 1;
    localparam int DEF_K     = 3;

    // $clog2 returns 0 for n <= 1, which would make a zero-width port.
    function automatic int cw(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_window_mux.sv
// conv_window_mux: combinational KxK window extractor.
//   i_buf : flattened frame, row y at [y*IMG_W*PIX_W +: IMG_W*PIX_W],
//           pixel x of a row at [x*PIX_W +: PIX_W]
//   i_row : top row of the window
//   i_col : left column of the window
//   o_win : element (i,j) = pixel (i_row+i, i_col+j) at [(i*K+j)*PIX_W +: PIX_W]
module conv_window_mux
    import conv_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W,
    parameter int K     = DEF_K
) (
    input  logic [IMG_H*IMG_W*PIX_W-1:0] i_buf,
    input  logic [cw(IMG_H)-1:0]         i_row,
    input  logic [cw(IMG_W)-1:0]         i_col,
    output logic [K*K*PIX_W-1:0]         o_win
);

    always_comb begin
        o_win = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                o_win[(i*K+j)*PIX_W +: PIX_W] =
                    i_buf[((int'(i_row) + i)*IMG_W + int'(i_col) + j)*PIX_W +: PIX_W];
            end
        end
    end

endmodule

// File: rtl/conv_frame_loader.sv
// conv_frame_loader: captures IMG_H rows (one per rising edge of row_strobe)
// into a frame buffer, then streams every valid KxK window over valid/ready.
//   clk, rst_n        : clock, asynchronous active-low reset
//   row_data          : one row of pixels, loaded on a row_strobe rise in LOAD
//   row_strobe        : level input, only its rising edge matters
//   frame_clear       : synchronous abort back to LOAD (buffer kept)
//   start             : begin streaming, honoured only when the frame is full
//   win_data/row/col  : current window and its top-left coordinate
//   win_valid/ready   : window handshake; win_last marks the final window
//   frame_full        : all rows loaded (held until the last window is taken)
//   overflow          : sticky, a strobe rise arrived while not loading
module conv_frame_loader
    import conv_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int PIX_W = DEF_PIX_W,
    parameter int K     = DEF_K
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [IMG_W*PIX_W-1:0]   row_data,
    input  logic                     row_strobe,
    input  logic                     frame_clear,
    input  logic                     start,
    output logic [K*K*PIX_W-1:0]     win_data,
    output logic [cw(IMG_H)-1:0]     win_row,
    output logic [cw(IMG_W)-1:0]     win_col,
    output logic                     win_valid,
    input  logic                     win_ready,
    output logic                     win_last,
    output logic                     frame_full,
    output logic                     overflow
);

    localparam int ROW_W = IMG_W*PIX_W;
    localparam int RW    = cw(IMG_H);
    localparam int CW    = cw(IMG_W);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H-1);
    localparam logic [RW-1:0] R_LAST   = RW'(IMG_H-K);
    localparam logic [CW-1:0] C_LAST   = CW'(IMG_W-K);

    if (K < 1 || K > IMG_W || K > IMG_H) begin : g_bad_k
        $error("conv_frame_loader: K must satisfy 1 <= K <= min(IMG_W, IMG_H)");
    end

    state_e                  r_state;
    logic [RW-1:0]           r_row_cnt;
    logic [RW-1:0]           r_r;
    logic [CW-1:0]           r_c;
    logic                    r_strobe_q;
    logic                    r_win_valid;
    logic                    r_frame_full;
    logic                    r_overflow;
    logic [IMG_H*ROW_W-1:0]  r_buf;

    logic                    w_rise;
    logic                    w_last;
    logic [K*K*PIX_W-1:0]    w_win;

    assign w_rise = row_strobe & ~r_strobe_q;
    assign w_last = r_win_valid & (r_r == R_LAST) & (r_c == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= LOAD;
            r_row_cnt    <= '0;
            r_r          <= '0;
            r_c          <= '0;
            r_strobe_q   <= 1'b0;
            r_win_valid  <= 1'b0;
            r_frame_full <= 1'b0;
            r_overflow   <= 1'b0;
            r_buf        <= '0;
        end else begin
            // Tracks the strobe even during a clear, so a rise coinciding
            // with frame_clear is consumed rather than replayed afterwards.
            r_strobe_q <= row_strobe;
            if (frame_clear) begin
                r_state      <= LOAD;
                r_row_cnt    <= '0;
                r_r          <= '0;
                r_c          <= '0;
                r_win_valid  <= 1'b0;
                r_frame_full <= 1'b0;
                r_overflow   <= 1'b0;
            end else begin
                unique case (r_state)
                    LOAD: begin
                        if (w_rise) begin
                            r_buf[int'(r_row_cnt)*ROW_W +: ROW_W] <= row_data;
                            if (r_row_cnt == ROW_LAST) begin
                                r_state      <= FULL;
                                r_row_cnt    <= '0;
                                r_frame_full <= 1'b1;
                            end else begin
                                r_row_cnt <= r_row_cnt + 1'b1;
                            end
                        end
                    end
                    FULL: begin
                        if (w_rise) r_overflow <= 1'b1;
                        if (start) begin
                            r_state     <= STREAM;
                            r_r         <= '0;
                            r_c         <= '0;
                            r_win_valid <= 1'b1;
                        end
                    end
                    STREAM: begin
                        if (w_rise) r_overflow <= 1'b1;
                        if (win_ready) begin
                            if (w_last) begin
                                r_state      <= LOAD;
                                r_win_valid  <= 1'b0;
                                r_frame_full <= 1'b0;
                                r_r          <= '0;
                                r_c          <= '0;
                            end else if (r_c == C_LAST) begin
                                r_c <= '0;
                                r_r <= r_r + 1'b1;
                            end else begin
                                r_c <= r_c + 1'b1;
                            end
                        end
                    end
                    default: r_state <= LOAD;
                endcase
            end
        end
    end

    conv_window_mux #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .PIX_W (PIX_W),
        .K     (K)
    ) u_mux (
        .i_buf (r_buf),
        .i_row (r_r),
        .i_col (r_c),
        .o_win (w_win)
    );

    // Window pixels are only shown while a window is presented; the buffer
    // survives frame_clear and would otherwise leak onto the bus.
    assign win_data   = r_win_valid ? w_win : '0;
    assign win_row    = r_r;
    assign win_col    = r_c;
    assign win_valid  = r_win_valid;
    assign win_last   = w_last;
    assign frame_full = r_frame_full;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_conv_frame_loader.sv
module tb_conv_frame_loader;

    localparam int IMG_W = 6;
    localparam int IMG_H = 6;
    localparam int PIX_W = 1;
    localparam int K     = 3;
    localparam int ROW_W = IMG_W*PIX_W;
    localparam int NC    = IMG_W-K+1;
    localparam int NR    = IMG_H-K+1;
    localparam int NWIN  = NR*NC;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [ROW_W-1:0]       row_data;
    logic                   row_strobe;
    logic                   frame_clear;
    logic                   start;
    logic [K*K*PIX_W-1:0]   win_data;
    logic [2:0]             win_row;
    logic [2:0]             win_col;
    logic                   win_valid;
    logic                   win_ready;
    logic                   win_last;
    logic                   frame_full;
    logic                   overflow;

    int n_cmp = 0;
    int n_err = 0;

    conv_frame_loader #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .K(K)) dut (
        .clk(clk), .rst_n(rst_n), .row_data(row_data), .row_strobe(row_strobe),
        .frame_clear(frame_clear), .start(start), .win_data(win_data),
        .win_row(win_row), .win_col(win_col), .win_valid(win_valid),
        .win_ready(win_ready), .win_last(win_last), .frame_full(frame_full),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame held as plain rows; streaming tracked as a linear window index.
    logic [ROW_W-1:0] mrow [IMG_H];
    int   mloaded;
    logic mprev, mfull, mstream, movf;
    int   mwin;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int y = 0; y < IMG_H; y++) mrow[y] <= '0;
            mprev <= 1'b0; mloaded <= 0; mfull <= 1'b0;
            mstream <= 1'b0; mwin <= 0; movf <= 1'b0;
        end else begin
            mprev <= row_strobe;
            if (frame_clear) begin
                mloaded <= 0; mfull <= 1'b0; mstream <= 1'b0; mwin <= 0; movf <= 1'b0;
            end else if (!mfull) begin
                if (row_strobe && !mprev) begin
                    mrow[mloaded] <= row_data;
                    if (mloaded + 1 == IMG_H) begin
                        mloaded <= 0; mfull <= 1'b1;
                    end else begin
                        mloaded <= mloaded + 1;
                    end
                end
            end else begin
                if (row_strobe && !mprev) movf <= 1'b1;
                if (!mstream) begin
                    if (start) begin mstream <= 1'b1; mwin <= 0; end
                end else if (win_ready) begin
                    if (mwin == NWIN-1) begin
                        mstream <= 1'b0; mfull <= 1'b0; mwin <= 0;
                    end else begin
                        mwin <= mwin + 1;
                    end
                end
            end
        end
    end

    function automatic logic [K*K*PIX_W-1:0] exp_win(input int wr, input int wc);
        logic [K*K*PIX_W-1:0] w;
        w = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
                w[(i*K+j)*PIX_W +: PIX_W] = mrow[wr+i][(wc+j)*PIX_W +: PIX_W];
        return w;
    endfunction

    always @(negedge clk) begin : cmp
        int wr, wc;
        wr = mstream ? mwin / NC : 0;
        wc = mstream ? mwin % NC : 0;
        chk("win_valid",  win_valid,  mstream);
        chk("frame_full", frame_full, mfull);
        chk("overflow",   overflow,   movf);
        chk("win_row",    win_row,    wr);
        chk("win_col",    win_col,    wc);
        chk("win_last",   win_last,   mstream && mwin == NWIN-1);
        chk("win_data",   win_data,   mstream ? exp_win(wr, wc) : '0);
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic load_row(input logic [ROW_W-1:0] d);
        row_data = d; row_strobe = 1'b1; cyc(1);
        row_strobe = 1'b0; cyc(1);
    endtask

    task automatic load_frame();
        for (int y = 0; y < IMG_H; y++) begin
            load_row(ROW_W'($urandom()));
            cyc($urandom_range(0, 2));
        end
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_data"},  win_data, 0);
        chk({nm, "_rc"},    {win_row, win_col}, 0);
        chk({nm, "_flags"}, {win_valid, win_last, frame_full, overflow}, 0);
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready/strobe/start
    task automatic stream(input int mode);
        logic done;
        done = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            case (mode)
                0: win_ready = 1'b1;
                1: win_ready = (t % 4 == 0) || (t % 4 == 3);
                default: begin
                    win_ready  = 1'($urandom_range(0, 1));
                    row_strobe = ($urandom_range(0, 7) == 0);
                    start      = 1'($urandom_range(0, 1));
                end
            endcase
            cyc(1);
            if (!win_valid) done = 1'b1;
        end
        chk("stream_terminates", done, 1);
        win_ready = 1'b0; row_strobe = 1'b0; start = 1'b0;
        cyc(1);
    endtask

    initial begin
        int nv, nl;
        rst_n = 1'b0; row_data = '0; row_strobe = 1'b0;
        frame_clear = 1'b0; start = 1'b0; win_ready = 1'b0;
        cyc(3);
        check_all_zero("reset");
        rst_n = 1'b1; cyc(1);

        // Identity diagonal frame; frame_full appears on the 6th write edge.
        for (int y = 0; y < IMG_H-1; y++) load_row(ROW_W'(1 << y));
        chk("full_before_6th", frame_full, 0);
        row_data = 6'h20; row_strobe = 1'b1; cyc(1);
        chk("full_at_6th_write", frame_full, 1);
        chk("no_overflow", overflow, 0);
        row_strobe = 1'b0; cyc(1);

        // Back-to-back streaming of the identity frame.
        start = 1'b1; cyc(1); start = 1'b0; win_ready = 1'b1;
        chk("first_valid", win_valid, 1);
        chk("first_window", win_data, 9'b100_010_001);
        chk("first_rc", {win_row, win_col}, 0);
        nv = 0; nl = 0;
        for (int t = 0; t < 40 && win_valid; t++) begin
            if (win_last) begin
                nl++;
                chk("last_pos", {win_row, win_col}, {3'd3, 3'd3});
            end
            nv++;
            cyc(1);
        end
        chk("window_count", nv, 16);
        chk("last_count", nl, 1);
        chk("full_after_stream", frame_full, 0);
        win_ready = 1'b0;

        // Held strobe loads exactly one row.
        row_data = ROW_W'($urandom()); row_strobe = 1'b1; cyc(10);
        row_strobe = 1'b0; cyc(1);
        for (int y = 0; y < IMG_H-2; y++) load_row(ROW_W'($urandom()));
        chk("held_strobe_not_full", frame_full, 0);
        load_row(ROW_W'($urandom()));
        chk("held_strobe_full", frame_full, 1);

        // 7th rise in FULL: overflow, buffer untouched (model checks contents).
        load_row(ROW_W'($urandom()));
        chk("overflow_7th", overflow, 1);
        chk("full_kept", frame_full, 1);
        stream(1);
        frame_clear = 1'b1; cyc(1); frame_clear = 1'b0;
        chk("clear_overflow", overflow, 0);
        chk("clear_full", frame_full, 0);

        // Reset while presenting window 5.
        load_frame();
        start = 1'b1; cyc(1); start = 1'b0; win_ready = 1'b1;
        cyc(5);
        chk("win5_rc", {win_row, win_col}, {3'd1, 3'd1});
        rst_n = 1'b0; #1;
        chk("async_reset_valid", win_valid, 0);
        win_ready = 1'b0; cyc(1);
        check_all_zero("midstream_reset");
        rst_n = 1'b1; cyc(1);
        for (int y = 0; y < IMG_H-1; y++) load_row(ROW_W'($urandom()));
        chk("post_reset_not_full", frame_full, 0);
        load_row(ROW_W'($urandom()));
        chk("post_reset_full", frame_full, 1);
        stream(2);

        // frame_clear with a simultaneous rise: rise dropped.
        frame_clear = 1'b1; cyc(1); frame_clear = 1'b0;
        load_row(ROW_W'($urandom()));
        load_row(ROW_W'($urandom()));
        row_data = ROW_W'($urandom()); frame_clear = 1'b1; row_strobe = 1'b1; cyc(1);
        frame_clear = 1'b0; row_strobe = 1'b0;
        check_all_zero("clear_with_rise");
        cyc(1);
        for (int y = 0; y < IMG_H-1; y++) load_row(ROW_W'($urandom()));
        chk("clear_rise_not_full", frame_full, 0);
        load_row(ROW_W'($urandom()));
        chk("clear_rise_full", frame_full, 1);
        stream(2);

        // Random frames with random back-pressure.
        repeat (4) begin
            frame_clear = 1'($urandom_range(0, 1)); cyc(1); frame_clear = 1'b0;
            load_frame();
            stream($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
